// File: rtl/bus_cmd_sequencer.sv
// Bus master that queues write / read / read-compare / wait commands in a FIFO and
// plays them onto the WR/RD/ADR/WDATA/RDATA slave bus with a configurable gap and read latency.
module bus_cmd_sequencer #(
  parameter int ADR_W     = 18,
  parameter int DATA_W    = 32,
  parameter int CMD_DEPTH = 16,
  parameter int GAP_CYC   = 1,
  parameter int RD_LAT    = 1
) (
  input  logic              CLK,
  input  logic              RESET_X,
  input  logic              EN,
  input  logic              CMD_VALID,
  output logic              CMD_READY,
  input  logic [1:0]        CMD_OP,
  input  logic [ADR_W-1:0]  CMD_ADR,
  input  logic [DATA_W-1:0] CMD_DATA,
  output logic              RSP_VALID,
  input  logic              RSP_READY,
  output logic [DATA_W-1:0] RSP_DATA,
  output logic              WR,
  output logic              RD,
  output logic [ADR_W-1:0]  ADR,
  output logic [DATA_W-1:0] WDATA,
  input  logic [DATA_W-1:0] RDATA,
  output logic              BUSY,
  output logic [15:0]       ERR_CNT,
  output logic [ADR_W-1:0]  ERR_ADR,
  input  logic              ERR_CLR
);

  localparam int IDX_W = $clog2(CMD_DEPTH);
  localparam int PTR_W = IDX_W + 1;
  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam int LAT_W = 2;

  typedef enum logic [1:0] {
    OP_WR   = 2'b00,
    OP_RD   = 2'b01,
    OP_RDC  = 2'b10,
    OP_WAIT = 2'b11
  } op_e;

  typedef struct packed {
    op_e               op;
    logic [ADR_W-1:0]  adr;
    logic [DATA_W-1:0] data;
  } cmd_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_RD_WAIT,
    S_GAP,
    S_WAIT
  } state_e;

  // ---------------------------------------------------------------------------
  // Command FIFO
  // ---------------------------------------------------------------------------
  cmd_t             fifo_mem [CMD_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W-1:0] fill_w;
  logic             empty_w, full_w, push_w, pop_w;
  cmd_t             head_w, cmd_in_w;

  assign fill_w   = wr_ptr_q - rd_ptr_q;
  assign empty_w  = (fill_w == '0);
  assign full_w   = (fill_w == PTR_W'(CMD_DEPTH));
  assign push_w   = CMD_VALID && !full_w;
  assign head_w   = fifo_mem[rd_ptr_q[IDX_W-1:0]];
  assign cmd_in_w = '{op: op_e'(CMD_OP), adr: CMD_ADR, data: CMD_DATA};

  // NOTE: storage has no reset; only the pointers define validity, so the array maps to plain RAM.
  always_ff @(posedge CLK) begin
    if (push_w) fifo_mem[wr_ptr_q[IDX_W-1:0]] <= cmd_in_w;
  end

  always_ff @(posedge CLK or negedge RESET_X) begin
    if (!RESET_X) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_w) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_w)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer FSM
  // ---------------------------------------------------------------------------
  state_e            state_q;
  cmd_t              cmd_q;
  logic              wr_q, rd_q;
  logic [ADR_W-1:0]  adr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [GAP_W-1:0]  gap_cnt_q;
  logic [LAT_W-1:0]  lat_cnt_q;
  logic [DATA_W-1:0] wait_cnt_q;
  logic              finish_w, lat_done_w, slot_free_w;

  assign lat_done_w  = (state_q == S_RD_WAIT) && (lat_cnt_q == LAT_W'(RD_LAT - 1));
  assign slot_free_w = !RSP_VALID || RSP_READY;

  // The last cycle of a command doubles as the IDLE cycle, so the next pop
  // overlaps it and write strobes land exactly GAP_CYC+1 cycles apart.
  // NOTE: assign a default before the case so no path leaves finish_w unassigned (no latch).
  always_comb begin
    finish_w = 1'b0;
    unique case (state_q)
      S_IDLE:    finish_w = 1'b1;
      S_ISSUE:   finish_w = (cmd_q.op == OP_WR) && (GAP_CYC == 0);
      S_RD_WAIT: finish_w = lat_done_w && (GAP_CYC == 0);
      S_GAP:     finish_w = (gap_cnt_q == GAP_W'(GAP_CYC - 1));
      S_WAIT:    finish_w = (wait_cnt_q == '0);
      default:   finish_w = 1'b0;
    endcase
  end

  assign pop_w = finish_w && EN && !empty_w;

  always_ff @(posedge CLK or negedge RESET_X) begin
    if (!RESET_X) begin
      state_q    <= S_IDLE;
      cmd_q      <= '0;
      wr_q       <= 1'b0;
      rd_q       <= 1'b0;
      adr_q      <= '0;
      wdata_q    <= '0;
      gap_cnt_q  <= '0;
      lat_cnt_q  <= '0;
      wait_cnt_q <= '0;
    end else begin
      // NOTE: strobes default low each cycle, so they are single-cycle pulses unless re-armed below.
      wr_q <= 1'b0;
      rd_q <= 1'b0;
      if (pop_w) begin
        cmd_q <= head_w;
        unique case (head_w.op)
          OP_WR: begin
            state_q <= S_ISSUE;
            wr_q    <= 1'b1;
            adr_q   <= head_w.adr;
            wdata_q <= head_w.data;
          end
          OP_RD, OP_RDC: begin
            state_q <= S_ISSUE;
            if (head_w.op == OP_RDC || slot_free_w) begin
              rd_q  <= 1'b1;
              adr_q <= head_w.adr;
            end
          end
          OP_WAIT: begin
            if (head_w.data != '0) begin
              state_q    <= S_WAIT;
              wait_cnt_q <= head_w.data - 1'b1;
            end else begin
              state_q <= S_IDLE;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end else if (finish_w) begin
        state_q <= S_IDLE;
      end else begin
        unique case (state_q)
          S_ISSUE: begin
            if (cmd_q.op == OP_WR) begin
              state_q   <= S_GAP;
              gap_cnt_q <= '0;
            end else if (rd_q) begin
              state_q   <= S_RD_WAIT;
              lat_cnt_q <= '0;
            end else if (slot_free_w) begin
              // A plain read stalls here until the response slot drains.
              rd_q  <= 1'b1;
              adr_q <= cmd_q.adr;
            end
          end
          S_RD_WAIT: begin
            if (lat_done_w) begin
              state_q   <= S_GAP;
              gap_cnt_q <= '0;
            end else begin
              lat_cnt_q <= lat_cnt_q + 1'b1;
            end
          end
          S_GAP:   gap_cnt_q  <= gap_cnt_q + 1'b1;
          S_WAIT:  wait_cnt_q <= wait_cnt_q - 1'b1;
          default: state_q    <= S_IDLE;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read response slot
  // ---------------------------------------------------------------------------
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_data_q;

  always_ff @(posedge CLK or negedge RESET_X) begin
    if (!RESET_X) begin
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else if (lat_done_w && cmd_q.op == OP_RD) begin
      rsp_valid_q <= 1'b1;
      rsp_data_q  <= RDATA;
    end else if (RSP_READY) begin
      rsp_valid_q <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Compare error tracking
  // ---------------------------------------------------------------------------
  logic [15:0]      err_cnt_q;
  logic [ADR_W-1:0] err_adr_q;
  logic             mismatch_w;

  assign mismatch_w = lat_done_w && (cmd_q.op == OP_RDC) && (RDATA != cmd_q.data);

  always_ff @(posedge CLK or negedge RESET_X) begin
    if (!RESET_X) begin
      err_cnt_q <= '0;
      err_adr_q <= '0;
    end else if (ERR_CLR) begin
      err_cnt_q <= '0;
      err_adr_q <= '0;
    end else if (mismatch_w) begin
      if (err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 1'b1;
      if (err_cnt_q == 16'h0000) err_adr_q <= cmd_q.adr;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign CMD_READY = !full_w;
  assign RSP_VALID = rsp_valid_q;
  assign RSP_DATA  = rsp_data_q;
  assign WR        = wr_q;
  assign RD        = rd_q;
  assign ADR       = adr_q;
  assign WDATA     = wdata_q;
  assign BUSY      = !empty_w || (state_q != S_IDLE);
  assign ERR_CNT   = err_cnt_q;
  assign ERR_ADR   = err_adr_q;

endmodule

// File: tb/tb_bus_cmd_sequencer.sv
// Directed self-checking bench for bus_cmd_sequencer: one task per scenario,
// with a tiny slave that returns rd_resp one cycle after each RD strobe.
module tb_bus_cmd_sequencer;

  localparam int ADR_W     = 18;
  localparam int DATA_W    = 32;
  localparam int CMD_DEPTH = 16;
  localparam int GAP_CYC   = 1;
  localparam int RD_LAT    = 1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              en, cmd_valid, cmd_ready;
  logic [1:0]        cmd_op;
  logic [ADR_W-1:0]  cmd_adr;
  logic [DATA_W-1:0] cmd_data;
  logic              rsp_valid, rsp_ready;
  logic [DATA_W-1:0] rsp_data;
  logic              wr, rd;
  logic [ADR_W-1:0]  adr;
  logic [DATA_W-1:0] wdata, rdata;
  logic              busy;
  logic [15:0]       err_cnt;
  logic [ADR_W-1:0]  err_adr;
  logic              err_clr;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [DATA_W-1:0] rd_resp = '0;
  int                wr_cyc [$];
  logic [ADR_W-1:0]  wr_adr_log [$];
  logic [DATA_W-1:0] wr_dat_log [$];
  int                rd_cnt        = 0;
  int                both_cnt      = 0;
  int                busy_fall_cyc = -1;
  logic              busy_prev     = 1'b0;

  always #5 clk = ~clk;

  bus_cmd_sequencer #(
    .ADR_W(ADR_W), .DATA_W(DATA_W), .CMD_DEPTH(CMD_DEPTH), .GAP_CYC(GAP_CYC), .RD_LAT(RD_LAT)
  ) dut (
    .CLK(clk), .RESET_X(rst_n), .EN(en),
    .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready), .CMD_OP(cmd_op), .CMD_ADR(cmd_adr), .CMD_DATA(cmd_data),
    .RSP_VALID(rsp_valid), .RSP_READY(rsp_ready), .RSP_DATA(rsp_data),
    .WR(wr), .RD(rd), .ADR(adr), .WDATA(wdata), .RDATA(rdata),
    .BUSY(busy), .ERR_CNT(err_cnt), .ERR_ADR(err_adr), .ERR_CLR(err_clr)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Slave: data is valid on RDATA in the cycle after the RD strobe (RD_LAT = 1).
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (rd) rdata <= rd_resp;
  end

  // Bus monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (wr) begin
      wr_cyc.push_back(cyc);
      wr_adr_log.push_back(adr);
      wr_dat_log.push_back(wdata);
    end
    if (rd)       rd_cnt   <= rd_cnt + 1;
    if (wr && rd) both_cnt <= both_cnt + 1;
    if (busy_prev && !busy) busy_fall_cyc <= cyc;
    busy_prev <= busy;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    wr_cyc.delete();
    wr_adr_log.delete();
    wr_dat_log.delete();
  endtask

  task automatic push(input logic [1:0] op, input logic [ADR_W-1:0] a, input logic [DATA_W-1:0] d);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_adr   = a;
    cmd_data  = d;
    for (int i = 0; i < 50; i++) begin
      if (cmd_ready) begin
        tick();
        cmd_valid = 1'b0;
        return;
      end
      tick();
    end
    cmd_valid = 1'b0;
    n_checks++;
    n_fail++;
    $display("FAIL push_timeout: CMD_READY stayed 0, required 1");
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 300; i++) begin
      if (!busy) begin
        tick();
        return;
      end
      tick();
    end
    n_checks++;
    n_fail++;
    $display("FAIL %s_idle_timeout: BUSY stayed 1, required 0", name);
  endtask

  task automatic wait_rsp(input string name);
    for (int i = 0; i < 50; i++) begin
      if (rsp_valid) return;
      tick();
    end
    n_checks++;
    n_fail++;
    $display("FAIL %s_rsp_timeout: RSP_VALID stayed 0, required 1", name);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_adr = '0; cmd_data = '0;
    rsp_ready = 1'b0; err_clr = 1'b0;
    repeat (3) tick();
    n_checks++;
    if ({wr, rd, busy, rsp_valid} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_ctrl: got %b, want 0000", {wr, rd, busy, rsp_valid});
    end
    n_checks++;
    if (cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_cmd_ready: got %b, want 1", cmd_ready);
    end
    n_checks++;
    if ({adr, wdata, rsp_data} !== '0) begin
      n_fail++; $display("FAIL reset_data: got %h %h %h, want 0", adr, wdata, rsp_data);
    end
    n_checks++;
    if ({err_cnt, err_adr} !== '0) begin
      n_fail++; $display("FAIL reset_err: got %h %h, want 0", err_cnt, err_adr);
    end
    rst_n = 1'b1;
    repeat (2) tick();
    n_checks++;
    if ({wr, rd, busy, cmd_ready} !== 4'b0001) begin
      n_fail++; $display("FAIL post_reset: got %b, want 0001", {wr, rd, busy, cmd_ready});
    end
  endtask

  task automatic test_single_write();
    int rd0;
    rd0 = rd_cnt;
    clear_log();
    en = 1'b1;
    push(2'b00, 18'h00010, 32'hDEADBEEF);
    wait_idle("single_write");
    n_checks++;
    if (wr_cyc.size() !== 1) begin
      n_fail++; $display("FAIL single_wr_count: got %0d, want 1", wr_cyc.size());
    end else begin
      n_checks++;
      if (wr_adr_log[0] !== 18'h00010 || wr_dat_log[0] !== 32'hDEADBEEF) begin
        n_fail++; $display("FAIL single_wr_vals: got %h/%h, want 00010/deadbeef", wr_adr_log[0], wr_dat_log[0]);
      end
      n_checks++;
      if (busy_fall_cyc - wr_cyc[0] !== GAP_CYC + 1) begin
        n_fail++; $display("FAIL busy_fall: got %0d, want %0d", busy_fall_cyc - wr_cyc[0], GAP_CYC + 1);
      end
    end
    n_checks++;
    if (adr !== 18'h00010 || wdata !== 32'hDEADBEEF || rd_cnt !== rd0) begin
      n_fail++; $display("FAIL single_hold: got %h/%h rd=%0d, want 00010/deadbeef rd=%0d", adr, wdata, rd_cnt, rd0);
    end
  endtask

  task automatic test_back_to_back();
    int rd0;
    rd0 = rd_cnt;
    clear_log();
    en = 1'b0;
    for (int i = 0; i < 3; i++) push(2'b00, ADR_W'(18'h00100 + i), DATA_W'(32'hA0 + i));
    en = 1'b1;
    wait_idle("back_to_back");
    n_checks++;
    if (wr_cyc.size() !== 3) begin
      n_fail++; $display("FAIL b2b_count: got %0d, want 3", wr_cyc.size());
    end else begin
      n_checks++;
      if (wr_cyc[1] - wr_cyc[0] !== 2 || wr_cyc[2] - wr_cyc[1] !== 2) begin
        n_fail++; $display("FAIL b2b_spacing: got %0d,%0d, want 2,2", wr_cyc[1] - wr_cyc[0], wr_cyc[2] - wr_cyc[1]);
      end
      n_checks++;
      if (wr_adr_log[2] !== 18'h00102 || wr_dat_log[2] !== 32'hA2) begin
        n_fail++; $display("FAIL b2b_last: got %h/%h, want 00102/000000a2", wr_adr_log[2], wr_dat_log[2]);
      end
    end
    n_checks++;
    if (rd_cnt !== rd0 || both_cnt !== 0) begin
      n_fail++; $display("FAIL b2b_no_rd: got rd=%0d both=%0d, want rd=%0d both=0", rd_cnt, both_cnt, rd0);
    end
  endtask

  task automatic test_read();
    int rd0;
    rd0 = rd_cnt;
    en = 1'b1;
    rsp_ready = 1'b0;
    rd_resp = 32'h12345678;
    push(2'b01, 18'h00020, '0);
    wait_rsp("read1");
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'h12345678) begin
      n_fail++; $display("FAIL read1_data: got %b/%h, want 1/12345678", rsp_valid, rsp_data);
    end
    n_checks++;
    if (adr !== 18'h00020 || rd_cnt !== rd0 + 1) begin
      n_fail++; $display("FAIL read1_bus: got %h rd=%0d, want 00020 rd=%0d", adr, rd_cnt, rd0 + 1);
    end
    rd_resp = 32'hCAFEF00D;
    push(2'b01, 18'h00021, '0);
    repeat (10) tick();
    n_checks++;
    if (rd_cnt !== rd0 + 1) begin
      n_fail++; $display("FAIL read2_stall: got rd=%0d, want %0d", rd_cnt, rd0 + 1);
    end
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 32'h12345678) begin
      n_fail++; $display("FAIL read1_hold: got %b/%h, want 1/12345678", rsp_valid, rsp_data);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    n_checks++;
    if (rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL read1_handshake: got %b, want 0", rsp_valid);
    end
    wait_rsp("read2");
    n_checks++;
    if (rsp_data !== 32'hCAFEF00D || adr !== 18'h00021 || rd_cnt !== rd0 + 2) begin
      n_fail++; $display("FAIL read2_data: got %h %h rd=%0d, want cafef00d 00021 rd=%0d", rsp_data, adr, rd_cnt, rd0 + 2);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    wait_idle("read");
    n_checks++;
    if (rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL read_drain: got %b, want 0", rsp_valid);
    end
  endtask

  task automatic test_compare();
    bit seen;
    en = 1'b1;
    rd_resp = 32'h2;
    push(2'b10, 18'h00030, 32'h1);
    push(2'b10, 18'h00031, 32'h1);
    wait_idle("cmp_two");
    n_checks++;
    if (err_cnt !== 16'd2 || err_adr !== 18'h00030) begin
      n_fail++; $display("FAIL cmp_two: got %0d/%h, want 2/00030", err_cnt, err_adr);
    end
    rd_resp = 32'h5;
    push(2'b10, 18'h00032, 32'h5);
    wait_idle("cmp_match");
    n_checks++;
    if (err_cnt !== 16'd2 || rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL cmp_match: got %0d rsp=%b, want 2 rsp=0", err_cnt, rsp_valid);
    end
    rd_resp = 32'h2;
    en = 1'b0;
    push(2'b10, 18'h00034, 32'h1);
    en = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (rd) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    n_checks++;
    if (!seen) begin
      n_fail++; $display("FAIL cmp_rd_seen: got 0, want 1");
    end
    repeat (RD_LAT) tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    n_checks++;
    if (err_cnt !== 16'd0 || err_adr !== '0) begin
      n_fail++; $display("FAIL cmp_clr_wins: got %0d/%h, want 0/00000", err_cnt, err_adr);
    end
    wait_idle("cmp_clr");
    push(2'b10, 18'h00035, 32'h1);
    wait_idle("cmp_after_clr");
    n_checks++;
    if (err_cnt !== 16'd1 || err_adr !== 18'h00035) begin
      n_fail++; $display("FAIL cmp_after_clr: got %0d/%h, want 1/00035", err_cnt, err_adr);
    end
  endtask

  task automatic test_fifo_full();
    bit accepted;
    int bad;
    clear_log();
    en = 1'b0;
    for (int i = 0; i < CMD_DEPTH; i++) push(2'b00, ADR_W'(18'h00200 + i), DATA_W'(32'h1000 + i));
    n_checks++;
    if (cmd_ready !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL full_ready: got rdy=%b busy=%b, want 0/1", cmd_ready, busy);
    end
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_adr = 18'h00210; cmd_data = 32'h1010;
    repeat (3) tick();
    n_checks++;
    if (cmd_ready !== 1'b0 || wr_cyc.size() !== 0) begin
      n_fail++; $display("FAIL full_paused: got rdy=%b wr=%0d, want 0/0", cmd_ready, wr_cyc.size());
    end
    en = 1'b1;
    accepted = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (cmd_ready) begin
        tick();
        accepted = 1'b1;
        break;
      end
      tick();
    end
    cmd_valid = 1'b0;
    n_checks++;
    if (!accepted) begin
      n_fail++; $display("FAIL full_17th_accept: got 0, want 1");
    end
    wait_idle("fifo_full");
    n_checks++;
    if (wr_cyc.size() !== CMD_DEPTH + 1) begin
      n_fail++; $display("FAIL full_count: got %0d, want %0d", wr_cyc.size(), CMD_DEPTH + 1);
    end else begin
      bad = 0;
      for (int i = 0; i <= CMD_DEPTH; i++) begin
        if (wr_adr_log[i] !== ADR_W'(18'h00200 + i) || wr_dat_log[i] !== DATA_W'(32'h1000 + i)) bad++;
        if (i > 0 && wr_cyc[i] - wr_cyc[i-1] !== GAP_CYC + 1) bad++;
      end
      n_checks++;
      if (bad !== 0) begin
        n_fail++; $display("FAIL full_order: got %0d bad entries, want 0", bad);
      end
    end
  endtask

  task automatic test_wait();
    bit seen;
    int rd0;
    clear_log();
    en = 1'b0;
    push(2'b00, 18'h00040, 32'hA);
    push(2'b11, '0, 32'd5);
    push(2'b00, 18'h00041, 32'hB);
    en = 1'b1;
    wait_idle("wait");
    n_checks++;
    if (wr_cyc.size() !== 2) begin
      n_fail++; $display("FAIL wait_count: got %0d, want 2", wr_cyc.size());
    end else begin
      n_checks++;
      if (wr_cyc[1] - wr_cyc[0] !== 1 + GAP_CYC + 5) begin
        n_fail++; $display("FAIL wait_spacing: got %0d, want %0d", wr_cyc[1] - wr_cyc[0], 1 + GAP_CYC + 5);
      end
    end
    rd0 = rd_cnt;
    clear_log();
    en = 1'b0;
    push(2'b00, 18'h00050, 32'h1);
    push(2'b11, '0, 32'd20);
    push(2'b00, 18'h00051, 32'h2);
    en = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (wr_cyc.size() == 1) begin
        seen = 1'b1;
        break;
      end
      tick();
    end
    n_checks++;
    if (!seen) begin
      n_fail++; $display("FAIL wait_first_wr: got 0 strobes, want 1");
    end
    repeat (5) tick();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (40) tick();
    n_checks++;
    if (wr_cyc.size() !== 1 || rd_cnt !== rd0) begin
      n_fail++; $display("FAIL reset_mid_wait_strobes: got wr=%0d rd=%0d, want 1/%0d", wr_cyc.size(), rd_cnt, rd0);
    end
    n_checks++;
    if (busy !== 1'b0 || cmd_ready !== 1'b1 || adr !== '0 || err_cnt !== '0) begin
      n_fail++; $display("FAIL reset_mid_wait_state: got busy=%b rdy=%b adr=%h err=%0d, want 0/1/0/0", busy, cmd_ready, adr, err_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_back_to_back();
    test_read();
    test_compare();
    test_fifo_full();
    test_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
